// File: rtl/cnn_layer_accel_layer_engine_pe_arb_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_layer_engine_pe_arb_pkg
// Shared types and helpers for the layer-engine PE return-channel arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, LOCK=1)
//   rr_next()   : round-robin pointer increment that wraps at n-1, so lane
//                 counts that are not a power of two wrap correctly
// -----------------------------------------------------------------------------
package cnn_layer_accel_layer_engine_pe_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_layer_engine_pe_arb_if.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_layer_engine_pe_arb_if
// Bundles the PE-side packet streams and the shared return channel.
//   pe_valid/pe_accept/pe_data : C_NUM_PE request lanes, lane i at [i*W +: W]
//   arb_valid/arb_accept/...   : merged output stream, tagged with arb_pe_id
//   arb_busy, err_burst_ovf    : status
// Modports:
//   master : the arbiter (drives pe_accept and the merged output)
//   slave  : the environment (PE lanes and downstream consumer)
// -----------------------------------------------------------------------------
interface cnn_layer_accel_layer_engine_pe_arb_if #(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4
);
  localparam int IdW = $clog2(C_NUM_PE);

  logic [C_NUM_PE-1:0]                pe_valid;
  logic [C_NUM_PE-1:0]                pe_accept;
  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] pe_data;
  logic                               arb_valid;
  logic                               arb_accept;
  logic [C_PACKET_WIDTH-1:0]          arb_data;
  logic [IdW-1:0]                     arb_pe_id;
  logic                               arb_busy;
  logic                               err_burst_ovf;

  modport master (
    input  pe_valid, pe_data, arb_accept,
    output pe_accept, arb_valid, arb_data, arb_pe_id, arb_busy, err_burst_ovf
  );

  modport slave (
    output pe_valid, pe_data, arb_accept,
    input  pe_accept, arb_valid, arb_data, arb_pe_id, arb_busy, err_burst_ovf
  );

endinterface

// File: rtl/cnn_layer_accel_layer_engine_pe_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_layer_engine_pe_arb_rr_pick
// Combinational round-robin priority picker: the first requesting lane found
// searching ptr_i, ptr_i+1, ... (mod N) wins.
//   req_i     : per-lane request
//   ptr_i     : highest-priority lane index (always < N)
//   gnt_o     : one-hot grant (zero when nothing requests)
//   gnt_idx_o : index of the granted lane
//   any_o     : at least one lane requests
// -----------------------------------------------------------------------------
module cnn_layer_accel_layer_engine_pe_arb_rr_pick #(
  parameter  int N   = 4,
  localparam int IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] gnt_idx_o,
  output logic           any_o
);

  logic [IdW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment, so
    // no path leaves a signal unassigned and no latch is inferred.
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo N (not 2^IdW) keeps the search inside the real lanes.
      idx = IdW'((32'(ptr_i) + 32'(k)) % N);
      if (!any_o && req_i[idx]) begin
        any_o     = 1'b1;
        gnt_idx_o = idx;
      end
    end
    gnt_o[gnt_idx_o] = any_o;
  end

endmodule

// File: rtl/cnn_layer_accel_layer_engine_pe_arb.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_layer_engine_pe_arb
// Shares one layer-engine return channel among C_NUM_PE PE packet streams.
// Round-robin, packet-locked: a granted lane keeps the channel until it sends
// a beat with LAST (bit C_PACKET_WIDTH-1) set, or until C_MAX_BURST beats have
// passed, in which case the grant is forcibly released and err_burst_ovf
// pulses. The output is a single registered elastic stage tagged with the
// source lane index.
//   clk    : clock
//   rst    : asynchronous reset, active-high
//   arb_if : master modport of cnn_layer_accel_layer_engine_pe_arb_if
// -----------------------------------------------------------------------------
module cnn_layer_accel_layer_engine_pe_arb
  import cnn_layer_accel_layer_engine_pe_arb_pkg::*;
#(
  parameter int C_PACKET_WIDTH = 66,
  parameter int C_NUM_PE       = 4,
  parameter int C_MAX_BURST    = 64
) (
  input logic clk,
  input logic rst,
  cnn_layer_accel_layer_engine_pe_arb_if.master arb_if
);

  localparam int IdW     = $clog2(C_NUM_PE);
  localparam int CntW    = $clog2(C_MAX_BURST + 1);
  localparam int LastBit = C_PACKET_WIDTH - 1;

  arb_state_e                state_q, state_d;
  logic [IdW-1:0]            gnt_q, gnt_d;
  logic [C_NUM_PE-1:0]       gnt_oh_q, gnt_oh_d;
  logic [IdW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                      arb_valid_q, arb_valid_d;
  logic [C_PACKET_WIDTH-1:0] arb_data_q, arb_data_d;
  logic [IdW-1:0]            arb_pe_id_q, arb_pe_id_d;
  logic                      err_q, err_d;

  logic [C_NUM_PE-1:0]       pick_gnt;
  logic [IdW-1:0]            pick_idx;
  logic                      pick_any;
  logic                      out_free;
  logic                      beat_take;
  logic                      burst_end;
  logic [C_PACKET_WIDTH-1:0] lane_data;

  cnn_layer_accel_layer_engine_pe_arb_rr_pick #(
    .N (C_NUM_PE)
  ) u_rr_pick (
    .req_i     (arb_if.pe_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (pick_gnt),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // The output stage can take a new beat when empty or being drained this cycle.
  assign out_free  = !arb_valid_q || arb_if.arb_accept;
  assign lane_data = arb_if.pe_data[32'(gnt_q)*C_PACKET_WIDTH +: C_PACKET_WIDTH];
  assign beat_take = (state_q == ST_LOCK) && out_free && arb_if.pe_valid[gnt_q];
  assign burst_end = (beat_cnt_q == CntW'(C_MAX_BURST - 1));

  assign arb_if.pe_accept     = (state_q == ST_LOCK && out_free) ? gnt_oh_q : '0;
  assign arb_if.arb_valid     = arb_valid_q;
  assign arb_if.arb_data      = arb_data_q;
  assign arb_if.arb_pe_id     = arb_pe_id_q;
  assign arb_if.arb_busy      = (state_q == ST_LOCK);
  assign arb_if.err_burst_ovf = err_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    arb_valid_d = arb_valid_q && !arb_if.arb_accept;
    arb_data_d  = arb_data_q;
    arb_pe_id_d = arb_pe_id_q;
    err_d       = 1'b0;

    case (state_q)
      // Grant only; no beat moves here, costing one bubble per packet.
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_LOCK;
          gnt_d      = pick_idx;
          gnt_oh_d   = pick_gnt;
          beat_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (beat_take) begin
          arb_valid_d = 1'b1;
          arb_data_d  = lane_data;
          arb_pe_id_d = gnt_q;
          if (lane_data[LastBit] || burst_end) begin
            // A truncated burst leaves the rest of the lane's beats to be
            // arbitrated again as a fresh packet.
            state_d    = ST_IDLE;
            rr_ptr_d   = IdW'(rr_next(32'(gnt_q), C_NUM_PE));
            beat_cnt_d = '0;
            err_d      = !lane_data[LastBit];
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // NOTE: the output data register is reset too, because every output must
  // read 0 while rst is asserted, not just the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      arb_valid_q <= 1'b0;
      arb_data_q  <= '0;
      arb_pe_id_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      arb_valid_q <= arb_valid_d;
      arb_data_q  <= arb_data_d;
      arb_pe_id_q <= arb_pe_id_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_layer_engine_pe_arb.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_accel_layer_engine_pe_arb
// Directed bench for the PE return-channel arbiter (4 lanes, 66-bit beats,
// burst limit 4). Each lane is a queue of beats presented on pe_valid/pe_data
// and popped when the arbiter accepts; accepted output beats are logged and
// compared against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_cnn_layer_accel_layer_engine_pe_arb;

  localparam int W   = 66;
  localparam int N   = 4;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_layer_accel_layer_engine_pe_arb_if #(.C_PACKET_WIDTH(W), .C_NUM_PE(N)) bus ();

  cnn_layer_accel_layer_engine_pe_arb #(
    .C_PACKET_WIDTH (W),
    .C_NUM_PE       (N),
    .C_MAX_BURST    (MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] lane_q [N][$];
  logic [N-1:0] lane_en;
  logic         acc_en;
  logic [1:0]   out_id [$];
  logic [W-1:0] out_data [$];
  int           err_pulses;

  function automatic logic [W-1:0] mk_beat(input logic last, input int lane, input int seq);
    logic [W-1:0] b;
    b        = '0;
    b[W-1]   = last;
    b[15:8]  = 8'(lane);
    b[7:0]   = 8'(seq);
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (lane_en[i] && lane_q[i].size() > 0) begin
        bus.pe_valid[i]        = 1'b1;
        bus.pe_data[i*W +: W]  = lane_q[i][0];
      end else begin
        bus.pe_valid[i]        = 1'b0;
        bus.pe_data[i*W +: W]  = '0;
      end
    end
    bus.arb_accept = acc_en;
  endtask

  // Record handshakes at the falling edge (stable values the next rising edge
  // will act on), then update lane drives 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (bus.pe_valid[i] && bus.pe_accept[i]) void'(lane_q[i].pop_front());
    if (bus.arb_valid && bus.arb_accept) begin
      out_id.push_back(bus.arb_pe_id);
      out_data.push_back(bus.arb_data);
    end
    if (bus.err_burst_ovf) err_pulses++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) lane_q[i].delete();
    out_id.delete();
    out_data.delete();
    lane_en    = '0;
    acc_en     = 1'b1;
    err_pulses = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_env();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.arb_valid !== 1'b0 || bus.pe_accept !== '0 || bus.arb_busy !== 1'b0 ||
        bus.err_burst_ovf !== 1'b0 || bus.arb_data !== '0 || bus.arb_pe_id !== '0) begin
      failures++;
      $display("FAIL %s: valid=%b accept=%b busy=%b err=%b data=%h id=%0d, required all 0",
               tag, bus.arb_valid, bus.pe_accept, bus.arb_busy, bus.err_burst_ovf,
               bus.arb_data, bus.arb_pe_id);
    end
  endtask

  // Compares the logged output stream with an expected id/data sequence.
  task automatic check_stream(input string tag, input logic [1:0] exp_id [$],
                              input logic [W-1:0] exp_data [$]);
    checks++;
    if (out_id.size() != exp_id.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d beats, required %0d", tag, out_id.size(), exp_id.size());
    end
    for (int i = 0; i < exp_id.size() && i < out_id.size(); i++) begin
      checks++;
      if (out_id[i] !== exp_id[i] || out_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL %s_beat%0d: got id=%0d data=%h, required id=%0d data=%h",
                 tag, i, out_id[i], out_data[i], exp_id[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_env();
    drive();
    #1;
    check_outputs_zero("reset_state");
    do_reset();
    check_outputs_zero("after_reset_release");
  endtask

  task automatic test_single_lane();
    logic [1:0]   eid [$];
    logic [W-1:0] edat [$];
    do_reset();
    for (int s = 0; s < 3; s++) lane_q[2].push_back(mk_beat(s == 2, 2, s));
    lane_en = 4'b0100;
    drive();
    step();
    checks++;
    if (bus.arb_valid !== 1'b0 || bus.arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant_cycle: valid=%b busy=%b, required valid=0 busy=1",
               bus.arb_valid, bus.arb_busy);
    end
    step();
    checks++;
    if (bus.arb_valid !== 1'b1 || bus.arb_pe_id !== 2'd2 || bus.arb_data !== mk_beat(0, 2, 0)) begin
      failures++;
      $display("FAIL single_first_beat: valid=%b id=%0d data=%h, required valid=1 id=2 data=%h",
               bus.arb_valid, bus.arb_pe_id, bus.arb_data, mk_beat(0, 2, 0));
    end
    repeat (6) step();
    for (int s = 0; s < 3; s++) begin
      eid.push_back(2'd2);
      edat.push_back(mk_beat(s == 2, 2, s));
    end
    check_stream("single", eid, edat);
    // Pointer now sits at 3: with every lane requesting, lane 3 must win.
    out_id.delete();
    out_data.delete();
    for (int i = 0; i < N; i++) lane_q[i].push_back(mk_beat(1, i, 9));
    lane_en = '1;
    drive();
    repeat (4) step();
    checks++;
    if (out_id.size() < 1 || out_id[0] !== 2'd3) begin
      failures++;
      $display("FAIL single_rr_ptr_next: got first id=%0d (beats=%0d), required 3",
               (out_id.size() > 0) ? out_id[0] : 2'd0, out_id.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]   eid [$];
    logic [W-1:0] edat [$];
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) lane_q[i].push_back(mk_beat(1, i, p));
    lane_en = '1;
    drive();
    repeat (20) step();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        eid.push_back(2'(i));
        edat.push_back(mk_beat(1, i, p));
      end
    check_stream("rr", eid, edat);
  endtask

  task automatic test_backpressure();
    logic [1:0]   eid [$];
    logic [W-1:0] edat [$];
    do_reset();
    for (int s = 0; s < 3; s++) lane_q[3].push_back(mk_beat(s == 2, 3, s));
    lane_en = 4'b1000;
    drive();
    step();
    step();
    acc_en = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.arb_valid !== 1'b1 || bus.arb_pe_id !== 2'd3 ||
          bus.arb_data !== mk_beat(0, 3, 0) || bus.pe_accept !== 4'b0000) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b id=%0d data=%h accept=%b, required valid=1 id=3 data=%h accept=0000",
                 c, bus.arb_valid, bus.arb_pe_id, bus.arb_data, bus.pe_accept, mk_beat(0, 3, 0));
      end
      step();
    end
    acc_en = 1'b1;
    drive();
    repeat (6) step();
    for (int s = 0; s < 3; s++) begin
      eid.push_back(2'd3);
      edat.push_back(mk_beat(s == 2, 3, s));
    end
    check_stream("hold", eid, edat);
  endtask

  task automatic test_burst_ovf();
    logic [1:0]   eid [$];
    logic [W-1:0] edat [$];
    do_reset();
    for (int s = 0; s < 6; s++) lane_q[1].push_back(mk_beat(0, 1, s));
    lane_q[0].push_back(mk_beat(1, 0, 0));
    lane_en = 4'b0010;
    drive();
    step();
    lane_en = 4'b0011;
    drive();
    repeat (12) step();
    for (int s = 0; s < 4; s++) begin
      eid.push_back(2'd1);
      edat.push_back(mk_beat(0, 1, s));
    end
    eid.push_back(2'd0);
    edat.push_back(mk_beat(1, 0, 0));
    for (int s = 4; s < 6; s++) begin
      eid.push_back(2'd1);
      edat.push_back(mk_beat(0, 1, s));
    end
    check_stream("burst", eid, edat);
    checks++;
    if (err_pulses != 1) begin
      failures++;
      $display("FAIL burst_err_pulses: got %0d cycles of err_burst_ovf, required 1", err_pulses);
    end
    // Lane 1 re-arbitrated its tail without LAST and now waits with no valid.
    checks++;
    if (bus.arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL burst_wait_locked: busy=%b, required 1", bus.arb_busy);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    lane_q[1].push_back(mk_beat(1, 1, 0));
    lane_en = 4'b0010;
    drive();
    repeat (4) step();
    for (int s = 0; s < 4; s++) lane_q[1].push_back(mk_beat(s == 3, 1, s + 1));
    drive();
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_async");
    clear_env();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].push_back(mk_beat(1, i, 7));
    lane_en = '1;
    drive();
    repeat (4) step();
    checks++;
    if (out_id.size() < 1 || out_id[0] !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_rr_ptr: got first id=%0d (beats=%0d), required 0",
               (out_id.size() > 0) ? out_id[0] : 2'd0, out_id.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_burst_ovf();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
